// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
  localparam int OS_DEFAULT = 16;
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return (clk_hz / (baud * os) < 1) ? 1 : clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (restart || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling 8N1 receiver with a one-entry valid/ready holding register
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = OS_DEFAULT,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  logic [1:0] sync_q;
  logic rxs, tick, restart, deliver_q, frame_err_q, load, xfer;
  state_e state_q;
  logic [SW-1:0] s_q;
  logic [BW-1:0] bit_q;
  logic [DATA_BITS-1:0] sh_q, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  assign rxs = sync_q[1];
  assign restart = state_q == IDLE && !rxs;
  uart_baud_tick #(.DIV(baud_div(CLK_HZ, BAUD, OVERSAMPLE))) u_tick (
    .clk(clk), .rst_n(rst_n), .restart(restart), .tick(tick)
  );
  // Shift right so the first (LSB) line bit ends up at bit 0 after DATA_BITS samples.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      s_q         <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: if (!rxs) begin
          state_q <= START;
          s_q     <= '0;
        end
        START: if (tick) begin
          if (s_q == S_HALF) begin
            state_q <= rxs ? IDLE : DATA;
            s_q     <= '0;
            bit_q   <= '0;
          end else s_q <= s_q + 1'b1;
        end
        DATA: if (tick) begin
          if (s_q == S_FULL) begin
            sh_q  <= {rxs, sh_q[DATA_BITS-1:1]};
            bit_q <= bit_q + 1'b1;
            s_q   <= '0;
            if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
          end else s_q <= s_q + 1'b1;
        end
        STOP: if (tick) begin
          if (s_q == S_FULL) begin
            deliver_q   <= rxs;
            frame_err_q <= !rxs;
            state_q     <= rxs ? IDLE : BREAK;
            s_q         <= '0;
          end else s_q <= s_q + 1'b1;
        end
        BREAK: if (rxs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign xfer = rx_valid_q && rx_ready;
  assign load = deliver_q && (!rx_valid_q || rx_ready);
  always_comb begin
    rx_valid_d = load || (rx_valid_q && !xfer);
    rx_data_d  = load ? sh_q : rx_data_q;
    overrun_d  = (deliver_q && !load) || (overrun_q && !xfer);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: table, corner-case and randomized frame checks against a byte-queue model
module tb_uart_rx_framer;
  localparam int BIT = 16;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks = 0, errors = 0, cyc = 0, ferr_cnt = 0, rise_cyc = -1, t0;
  logic prev_v = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  typedef struct {logic [7:0] d; logic stop; int n_valid; int n_ferr;} vec_t;
  vec_t tbl[6];

  uart_rx_framer #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe 1 time unit after the falling edge: inputs have settled, next rising edge is 4 units away.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = rx_valid;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt = 0;
    rise_cyc = -1;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n, exp_ferr;
    logic [7:0] d;
    logic ok;
    tbl[0] = '{8'h55, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1, 0};
    tbl[3] = '{8'hC4, 1'b0, 0, 1};
    tbl[4] = '{8'hA5, 1'b1, 1, 0};
    tbl[5] = '{8'h3C, 1'b0, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    rx_ready = 1'b1;
    clear_mon();
    t0 = cyc;
    send(8'h55, 1'b1);
    idle(10);
    chk("t1_latency_window", int'(rise_cyc - t0 >= 150 && rise_cyc - t0 <= 175), 1);
    chk("t1_count", got_q.size(), 1);
    chk("t1_data", got_q.size() > 0 ? got_q[0] : -1, 8'h55);
    chk("t1_ferr", ferr_cnt, 0);
    chk("t1_overrun", overrun, 0);

    foreach (tbl[i]) begin
      clear_mon();
      send(tbl[i].d, tbl[i].stop);
      idle(3 * BIT);
      chk($sformatf("tbl%0d_count", i), got_q.size(), tbl[i].n_valid);
      if (tbl[i].n_valid > 0) chk($sformatf("tbl%0d_data", i), got_q.size() > 0 ? got_q[0] : -1, tbl[i].d);
      chk($sformatf("tbl%0d_ferr", i), ferr_cnt, tbl[i].n_ferr);
      chk($sformatf("tbl%0d_valid_idle", i), rx_valid, 0);
    end

    rx_ready = 1'b0;
    clear_mon();
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    idle(2 * BIT);
    chk("t2_valid_held", rx_valid, 1);
    chk("t2_data_held", rx_data, 8'hA3);
    chk("t2_overrun_set", overrun, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t2_xfer_data", got_q.size() == 1 ? got_q[0] : -1, 8'hA3);
    chk("t2_valid_clear", rx_valid, 0);
    chk("t2_overrun_clear", overrun, 0);

    clear_mon();
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_count", got_q.size(), 0);
    chk("t3_ferr", ferr_cnt, 0);

    clear_mon();
    rxd = 1'b0;
    repeat (40 * BIT) @(negedge clk);
    idle(2 * BIT);
    chk("t4_break_ferr", ferr_cnt, 1);
    chk("t4_break_count", got_q.size(), 0);
    chk("t4_break_busy", busy, 0);

    clear_mon();
    send(8'h01, 1'b1);
    send(8'h80, 1'b1);
    send(8'hFF, 1'b1);
    idle(2 * BIT);
    chk("t5_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_order", got_q.size() > i ? got_q[i] : -1, i == 0 ? 8'h01 : i == 1 ? 8'h80 : 8'hFF);
    chk("t5_overrun", overrun, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", rx_valid, 0);
    chk("t5_rst_data", rx_data, 0);
    chk("t5_rst_overrun", overrun, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(12 * BIT);
    chk("t5_no_partial", got_q.size(), 3);
    chk("t5_valid_after", rx_valid, 0);

    rx_ready = 1'b0;
    clear_mon();
    send(8'h5A, 1'b1);
    idle(BIT);
    chk("t6_first_held", rx_valid, 1);
    n = 0;
    fork
      send(8'hC3, 1'b1);
      begin
        while (!busy && n < 400) begin @(negedge clk); n++; end
        while (busy && n < 400) begin @(negedge clk); n++; end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    chk("t6_busy_bound", int'(n < 400), 1);
    chk("t6_valid_kept", rx_valid, 1);
    chk("t6_new_data", rx_data, 8'hC3);
    chk("t6_overrun", overrun, 0);
    chk("t6_old_xfer", got_q.size() == 1 ? got_q[0] : -1, 8'h5A);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_new_xfer", got_q.size() == 2 ? got_q[1] : -1, 8'hC3);

    clear_mon();
    exp_q.delete();
    exp_ferr = 0;
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      ok = $urandom_range(0, 99) < 80;
      send(d, ok);
      if (ok) exp_q.push_back(d);
      else exp_ferr++;
      idle($urandom_range(4, 30));
    end
    idle(2 * BIT);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("rand_byte%0d", i), i < got_q.size() ? got_q[i] : -1, exp_q[i]);
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
